seq_array_mult: RTL and testbench
=================================

SEQ_ARRAY_MULT -- requirements
Module: seq_array_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..16.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the width of the internal bit counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-006 The block SHALL have port a, input, WIDTH bits: the multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH bits: the multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the product is valid.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the result.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 When start=1 in IDLE or DONE, the block SHALL, on the same edge, latch a and b, clear the accumulator and counter, and enter RUN.
REQ-013 When start=0 in IDLE, the block SHALL stay in IDLE.
REQ-014 When start=0 in DONE, the block SHALL go to IDLE.
REQ-015 In RUN, each edge SHALL add the shifted multiplicand to the accumulator if the current multiplier bit is 1, then shift and increment the counter (radix-2 shift-add, one partial-product row per cycle).
REQ-016 After exactly WIDTH RUN cycles the block SHALL enter DONE, so done is high in the cycle after the WIDTH-th RUN edge; latency is WIDTH+1 edges from start acceptance to done visible.
REQ-017 done SHALL be high only in DONE, for exactly one cycle per accepted start.
REQ-018 busy SHALL be high exactly in RUN.
REQ-019 product SHALL update only on the edge entering DONE.
REQ-020 product SHALL hold its value through IDLE and through any following RUN until the next DONE.
REQ-021 start while in RUN SHALL be ignored, with no restart and no queuing.
REQ-022 Changes on a or b after acceptance SHALL not affect the result.
REQ-023 In unsigned mode the arithmetic SHALL be product = a*b, exact in 2*WIDTH bits, so no overflow is possible.
REQ-024 Back-to-back operation SHALL be supported: start held high in DONE restarts with no idle cycle, giving a throughput of one result per WIDTH+1 cycles.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, product=0, counter=0 and accumulator=0.
REQ-026 rst SHALL take priority over start.
REQ-027 rst asserted mid-RUN SHALL abort the operation, so no done pulse follows, and product SHALL read 0.
REQ-028 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-029 Macro SIGNED_MULT_EN SHALL control the signed-multiply feature.
REQ-030 When SIGNED_MULT_EN is defined, the block SHALL add input port sgn, 1 bit, latched together with a and b on acceptance.
REQ-031 When SIGNED_MULT_EN is defined and the latched sgn=1, the block SHALL treat a and b as two's complement: multiplicand sign-extended to 2*WIDTH, and the final (MSB) row subtracted instead of added; product is then the signed 2*WIDTH-bit result.
REQ-032 When SIGNED_MULT_EN is defined and the latched sgn=0, behaviour SHALL be identical to unsigned mode.
REQ-033 When SIGNED_MULT_EN is defined, latency and handshake SHALL be unchanged.
REQ-034 When SIGNED_MULT_EN is not defined, port sgn SHALL be absent and the block SHALL be unsigned only.

Verification
REQ-035 The bench SHALL cover, with WIDTH=8: rst high 2 cycles, then released -> busy=0, done=0, product=16'h0000.
REQ-036 The bench SHALL cover: a=8'd13, b=8'd11, start pulsed 1 cycle -> busy high 8 cycles, done pulse on cycle 9, product=16'd143, held afterwards.
REQ-037 The bench SHALL cover: a=8'hFF, b=8'hFF -> product=16'hFE01; a=0, b=8'hA5 -> product=0.
REQ-038 The bench SHALL cover: start re-pulsed during RUN, with a and b changed to 8'd2 and 8'd3 -> ignored, original product delivered, exactly one done pulse.
REQ-039 The bench SHALL cover: rst asserted on RUN cycle 4 -> IDLE next edge, no done pulse, product=0; then 8'd7*8'd9 -> 16'd63.
REQ-040 The bench SHALL cover, with SIGNED_MULT_EN defined: sgn=1, a=8'hFD (-3), b=8'd5 -> product=16'hFFF1 (-15); sgn=1, a=8'h80, b=8'h80 -> 16'h4000; sgn=0, a=8'hFD, b=8'd5 -> 16'd1265.

Source files
------------

// File: rtl/seq_array_mult.sv
// Radix-2 shift-add multiplier: one partial-product row per clock, IDLE/RUN/DONE handshake.
// Optional two's-complement mode is enabled by defining SIGNED_MULT_EN (adds input sgn).
module seq_array_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MULT_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_last;
    logic                 w_sub;
    logic [2*WIDTH-1:0]   w_row;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_mcand_init;

`ifdef SIGNED_MULT_EN
    logic                 r_sgn;

    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so that row is subtracted.
    assign w_sub        = r_sgn && w_last;
    assign w_mcand_init = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
`else
    assign w_sub        = 1'b0;
    assign w_mcand_init = {{WIDTH{1'b0}}, a};
`endif

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_row      = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = w_sub ? (r_acc - w_row) : (r_acc + w_row);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
`ifdef SIGNED_MULT_EN
            r_sgn    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand  <= w_mcand_init;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
`ifdef SIGNED_MULT_EN
                        r_sgn    <= sgn;
`endif
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end

                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        product <= w_acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_mult.sv
// Scoreboard bench for seq_array_mult (WIDTH=8); signed cases run when SIGNED_MULT_EN is defined.
module tb_seq_array_mult;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sgn;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] exp_v;
    logic [2*WIDTH-1:0] last_prod;
    int                 n_pass;
    int                 n_total;

    seq_array_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef SIGNED_MULT_EN
        .sgn     (sgn),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] ia,
                                                 input logic [WIDTH-1:0] ib,
                                                 input logic isg);
        int sa;
        int sb;
        if (isg) begin
            sa = $signed(ia);
            sb = $signed(ib);
        end else begin
            sa = int'(ia);
            sb = int'(ib);
        end
        return 16'(sa * sb);
    endfunction

    // Drive one start pulse; leaves the caller at the falling edge just after acceptance.
    task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic isg, input bit record);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sgn   = isg;
        if (record) exp_q.push_back(model(ia, ib, isg));
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        sgn   = 1'($urandom);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pop_expected(output logic [2*WIDTH-1:0] v);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: no expected result queued");
            v = 'x;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        sgn   = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000)
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle_hold: busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_basic;
        int n_busy;
        int n_prod_ok;
        launch(8'd13, 8'd11, 1'b0, 1'b1);
        n_busy    = 0;
        n_prod_ok = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy === 1'b1 && done === 1'b0) n_busy++;
            if (product === 16'h0000) n_prod_ok++;
            @(negedge clk);
        end
        n_total++;
        if (n_busy !== WIDTH)
            $display("FAIL basic_busy_cycles: got %0d, want %0d", n_busy, WIDTH);
        else n_pass++;
        n_total++;
        if (n_prod_ok !== WIDTH)
            $display("FAIL basic_product_hold_in_run: %0d of %0d cycles held 0", n_prod_ok, WIDTH);
        else n_pass++;
        pop_expected(exp_v);
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== exp_v)
            $display("FAIL basic_done_cycle9: done=%b busy=%b product=%0d, want 1 0 %0d",
                     done, busy, product, exp_v);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || product !== 16'd143)
            $display("FAIL basic_one_pulse_hold: done=%b product=%0d, want 0 143", done, product);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (product !== 16'd143 || busy !== 1'b0)
            $display("FAIL basic_idle_hold: product=%0d busy=%b, want 143 0", product, busy);
        else n_pass++;
        last_prod = 16'd143;
    endtask

    task automatic test_values;
        logic [WIDTH-1:0] va[6];
        logic [WIDTH-1:0] vb[6];
        int cycles;
        va = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00};
        vb = '{8'hFF, 8'hA5, 8'h80, 8'h01, 8'h00, 8'h00};
        for (int i = 2; i < 6; i++) begin
            if (i >= 4) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
        end
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], 1'b0, 1'b1);
            n_total++;
            if (product !== last_prod)
                $display("FAIL values_hold_prev[%0d]: product=%h, want %h", i, product, last_prod);
            else n_pass++;
            wait_done(cycles);
            pop_expected(exp_v);
            n_total++;
            if (done !== 1'b1 || cycles !== WIDTH || product !== exp_v)
                $display("FAIL values[%0d] %h*%h: done=%b cycles=%0d product=%h, want 1 %0d %h",
                         i, va[i], vb[i], done, cycles, WIDTH, product, exp_v);
            else n_pass++;
            last_prod = exp_v;
        end
    endtask

    task automatic test_ignore_start;
        int n_done;
        logic [2*WIDTH-1:0] seen;
        launch(8'd25, 8'd4, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'd2;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        seen   = '0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) begin
                n_done++;
                seen = product;
            end
            @(negedge clk);
        end
        pop_expected(exp_v);
        n_total++;
        if (n_done !== 1 || seen !== exp_v)
            $display("FAIL ignore_start: done_pulses=%0d product=%0d, want 1 %0d", n_done, seen, exp_v);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || exp_q.size() !== 0)
            $display("FAIL ignore_start_no_queue: busy=%b pending=%0d, want 0 0", busy, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int n_done;
        int cycles;
        launch(8'd200, 8'd201, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000)
            $display("FAIL reset_mid_run: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        else n_pass++;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            @(negedge clk);
        end
        n_total++;
        if (n_done !== 0)
            $display("FAIL reset_abort_quiet: busy/done seen %0d cycles, want 0", n_done);
        else n_pass++;
        launch(8'd7, 8'd9, 1'b0, 1'b1);
        wait_done(cycles);
        pop_expected(exp_v);
        n_total++;
        if (done !== 1'b1 || product !== exp_v)
            $display("FAIL after_reset_7x9: done=%b product=%0d, want 1 %0d", done, product, exp_v);
        else n_pass++;
        last_prod = exp_v;
    endtask

    task automatic test_back_to_back;
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd4;
        sgn   = 1'b0;
        exp_q.push_back(model(8'd3, 8'd4, 1'b0));
        @(negedge clk);
        wait_done(cycles);
        pop_expected(exp_v);
        n_total++;
        if (done !== 1'b1 || cycles !== WIDTH || product !== exp_v)
            $display("FAIL b2b_first: done=%b cycles=%0d product=%0d, want 1 %0d %0d",
                     done, cycles, product, WIDTH, exp_v);
        else n_pass++;
        a = 8'd5;
        b = 8'd6;
        exp_q.push_back(model(8'd5, 8'd6, 1'b0));
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== exp_v)
            $display("FAIL b2b_no_idle: busy=%b done=%b product=%0d, want 1 0 %0d", busy, done, product, exp_v);
        else n_pass++;
        wait_done(cycles);
        pop_expected(exp_v);
        n_total++;
        if (done !== 1'b1 || cycles !== WIDTH || product !== exp_v)
            $display("FAIL b2b_second: done=%b cycles=%0d product=%0d, want 1 %0d %0d",
                     done, cycles, product, WIDTH, exp_v);
        else n_pass++;
        @(negedge clk);
        last_prod = exp_v;
    endtask

`ifdef SIGNED_MULT_EN
    task automatic test_signed;
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        logic             vs[4];
        logic [2*WIDTH-1:0] lit[3];
        int cycles;
        va  = '{8'hFD, 8'h80, 8'hFD, 8'h7F};
        vb  = '{8'd5,  8'h80, 8'd5,  8'hFF};
        vs  = '{1'b1,  1'b1,  1'b0,  1'b1};
        lit = '{16'hFFF1, 16'h4000, 16'd1265};
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vs[i], 1'b1);
            wait_done(cycles);
            pop_expected(exp_v);
            if (i < 3) exp_v = lit[i];
            n_total++;
            if (done !== 1'b1 || cycles !== WIDTH || product !== exp_v)
                $display("FAIL signed[%0d] sgn=%b %h*%h: done=%b cycles=%0d product=%h, want 1 %0d %h",
                         i, vs[i], va[i], vb[i], done, cycles, product, WIDTH, exp_v);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        n_pass    = 0;
        n_total   = 0;
        last_prod = '0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        sgn       = 1'b0;
        test_reset();
        test_basic();
        test_values();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SIGNED_MULT_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
